cond_grant_arb: RTL and testbench
=================================

# cond_grant_arb

Parametrised, clocked condition-qualified arbiter. It is the sequential, multi-channel successor to the flat enable/strobe decoders in the benchmark set. Each of N_CH channels raises a request qualified by a condition vector. A round-robin FSM grants one eligible channel at a time, holds the grant until the downstream `done` handshake or a programmable timeout, and keeps a saturating grant count. It sits between the per-channel condition logic and a shared downstream resource.

## Interface
- N_CH, 4, number of channels (2..16)
- CW, 8, condition vector width per channel
- TO_W, 6, timeout counter width
- CNT_W, 16, grant-count width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_CH  per-channel request level
- cond  in  N_CH*CW  condition vectors; channel i occupies bits [i*CW +: CW]
- mask  in  CW  global condition mask
- timeout_cfg  in  TO_W  grant timeout in cycles; 0 disables the timeout
- done  in  1  downstream completion; sampled only in BUSY
- gnt  out  N_CH  one-hot grant, all-zero when no grant
- gnt_id  out  clog2(N_CH)  index of the granted channel; holds its last value when idle
- busy  out  1  high while in BUSY
- err_to  out  1  one-cycle timeout pulse
- gnt_count  out  CNT_W  total grants issued, saturating

## Operation
- Eligibility: channel i is eligible when `req[i] & |(cond_i & mask)`. A channel with `mask = 0` is never eligible.
- FSM states: IDLE, BUSY, RELEASE. Encoding is free. IDLE is the reset state.
- IDLE:
  - If any channel is eligible, register the winner into `gnt`/`gnt_id` and go to BUSY.
  - Otherwise stay in IDLE.
- Round-robin search:
  - Start at `ptr`. Take the first eligible index scanning ptr, ptr+1, … with wrap at N_CH-1 -> 0.
  - On each grant, set `ptr <= winner+1`, wrapping to 0 after N_CH-1.
- BUSY:
  - `gnt` and `gnt_id` are held constant. Changes to `req`, `cond` or `mask` are ignored, so a dropped request does not revoke the grant.
  - `to_cnt` counts the BUSY cycles already elapsed.
  - If `done`=1, go to RELEASE. No error is raised.
  - Otherwise, if `timeout_cfg != 0` and `to_cnt == timeout_cfg-1`, go to RELEASE and assert `err_to` for the RELEASE cycle.
  - Otherwise increment `to_cnt`.
- Simultaneous `done` and timeout: `done` wins and `err_to` stays 0.
- RELEASE:
  - `gnt` is all-zero and `to_cnt` is cleared.
  - Always go to IDLE. No arbitration happens here.
- `gnt_count`:
  - Increments on each IDLE->BUSY transition.
  - Saturates at 2^CNT_W-1 and never wraps.
- `timeout_cfg` is sampled every BUSY cycle. A change mid-grant takes effect immediately.
  - If the new value is at or below the current `to_cnt`, no timeout fires for that grant. It ends only on `done`.

## Timing
- Reset values: gnt=0, gnt_id=0, busy=0, err_to=0, gnt_count=0. Internal: ptr=0, to_cnt=0, state=IDLE.
- Asserting `rst_n` at any time, including mid-BUSY, drops all outputs immediately and asynchronously, with no RELEASE cycle. Deassertion is synchronised externally.
- Request-to-grant latency:
  - An eligible request sampled at edge k gives `gnt`/`busy` high from edge k.
  - The request must be stable in the cycle before edge k.
- A grant with `done` sampled at the m-th BUSY edge gives exactly m cycles of `gnt` high.
- Timeout T gives exactly T cycles of `gnt` high, followed by one RELEASE cycle with `err_to`=1.
- Minimum spacing from the end of one grant to the next: 2 cycles (RELEASE, then IDLE).
- `err_to` is high only in RELEASE and never for two consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle:
  - Assert rst_n=0 mid-BUSY on ch2 -> all outputs 0 within the same cycle.
  - After release, first grant with all channels eligible -> gnt=4'b0001, gnt_id=0.
- Round-robin, N_CH=4, mask=8'hFF, all cond=8'h01, req=4'b1111, done pulsed 1 cycle after each grant:
  - Grant order is 0,1,2,3,0.
  - `gnt_count`=5.
  - Each grant is 1 cycle wide with a 2-cycle gap between grants.
- Condition masking: req=4'b1010, cond1=8'h10, cond3=8'h01, mask=8'h0F -> only ch3 is ever granted; ch1 never is.
- Timeout: timeout_cfg=5, done held 0 -> gnt high exactly 5 cycles, then err_to=1 for 1 cycle, then ptr advances.
- Timeout edge cases:
  - `done`=1 on the 5th BUSY cycle with timeout_cfg=5 -> err_to stays 0.
  - timeout_cfg=0 with done withheld 100 cycles -> grant held 100 cycles, no err_to.
- Saturation: CNT_W=4, run 20 grants -> gnt_count stops at 15.
- Request drop: req[ch] deasserted mid-BUSY -> grant persists until `done`.

Source files
------------

// File: rtl/cond_grant_arb.sv
// Purpose: condition-qualified round-robin arbiter that holds one grant until done or timeout.
// Latency: an eligible request sampled at an IDLE edge is granted from that edge; a RELEASE cycle and an IDLE cycle separate grants.
// Backpressure: a grant is held until done (or timeout); request/condition changes while BUSY are ignored.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   req[N_CH]           per-channel request level
//   cond[N_CH*CW]       per-channel condition vectors, channel i at [i*CW +: CW]
//   mask[CW]            global condition mask
//   timeout_cfg[TO_W]   grant timeout in cycles, 0 disables
//   done                downstream completion, sampled only while BUSY
//   gnt[N_CH]           one-hot grant, zero when idle
//   gnt_id              index of the granted channel, holds the last value when idle
//   busy                high while a grant is held
//   err_to              one-cycle pulse in the RELEASE cycle after a timeout
//   gnt_count[CNT_W]    saturating count of grants issued
module cond_grant_arb #(
   parameter int N_CH  = 4,
   parameter int CW    = 8,
   parameter int TO_W  = 6,
   parameter int CNT_W = 16,
   localparam int ID_W = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH-1:0]      req,
   input  logic [N_CH*CW-1:0]   cond,
   input  logic [CW-1:0]        mask,
   input  logic [TO_W-1:0]      timeout_cfg,
   input  logic                 done,
   output logic [N_CH-1:0]      gnt,
   output logic [ID_W-1:0]      gnt_id,
   output logic                 busy,
   output logic                 err_to,
   output logic [CNT_W-1:0]     gnt_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_REL
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ID_W-1:0]   ptr;
   logic [TO_W-1:0]   to_cnt;
   logic [N_CH-1:0]   elig;
   logic              win_vld;
   logic [ID_W-1:0]   win_id;
   logic              to_hit;
   int                rr_idx;

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_CH; i++) begin
         elig[i] = req[i] & (|(cond[i*CW +: CW] & mask));
      end
   end

   // Scan offsets from the far end back toward ptr so the lowest offset
   // from ptr is the last writer and therefore the winner.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      rr_idx  = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         rr_idx = (int'(ptr) + k) % N_CH;
         if (elig[rr_idx]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(rr_idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      to_hit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // done has priority over a coincident timeout
            if (done) begin
               state_d = ST_REL;
            end else if ((timeout_cfg != '0) && (to_cnt == timeout_cfg - TO_W'(1))) begin
               state_d = ST_REL;
               to_hit  = 1'b1;
            end
         end
         ST_REL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt       <= '0;
         gnt_id    <= '0;
         ptr       <= '0;
         to_cnt    <= '0;
         err_to    <= 1'b0;
         gnt_count <= '0;
      end else begin
         state_q <= state_d;
         err_to  <= to_hit;
         case (state_q)
            ST_IDLE: begin
               if (win_vld) begin
                  gnt    <= N_CH'(1) << win_id;
                  gnt_id <= win_id;
                  ptr    <= (win_id == ID_W'(N_CH - 1)) ? '0 : win_id + ID_W'(1);
                  to_cnt <= '0;
                  if (gnt_count != '1) begin
                     gnt_count <= gnt_count + CNT_W'(1);
                  end
               end
            end
            ST_BUSY: begin
               if (state_d == ST_REL) begin
                  gnt    <= '0;
                  to_cnt <= '0;
               end else if (to_cnt != '1) begin
                  // Saturate so a lowered timeout_cfg can never be matched
                  // later by a wrapped counter.
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            default: begin
               gnt    <= '0;
               to_cnt <= '0;
            end
         endcase
      end
   end

   assign busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_cond_grant_arb.sv
module tb_cond_grant_arb;

   localparam int N    = 4;
   localparam int CW   = 8;
   localparam int TW   = 6;
   localparam int CNTW = 4;
   localparam int IDW  = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*CW-1:0] cond;
   logic [CW-1:0]   mask;
   logic [TW-1:0]   timeout_cfg;
   logic            done;
   logic [N-1:0]    gnt;
   logic [IDW-1:0]  gnt_id;
   logic            busy;
   logic            err_to;
   logic [CNTW-1:0] gnt_count;

   cond_grant_arb #(.N_CH(N), .CW(CW), .TO_W(TW), .CNT_W(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .cond(cond), .mask(mask),
      .timeout_cfg(timeout_cfg), .done(done), .gnt(gnt), .gnt_id(gnt_id),
      .busy(busy), .err_to(err_to), .gnt_count(gnt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, for how many edges, and
   // how many edges must pass before arbitration is allowed again.
   int m_owner, m_held, m_cool, m_ptr, m_count, m_id;
   bit m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit eligible(input int c);
      return req[c] && ((cond[c*CW +: CW] & mask) != '0);
   endfunction

   task automatic m_reset();
      m_owner = -1; m_held = 0; m_cool = 0; m_ptr = 0; m_count = 0; m_id = 0; m_err = 0;
   endtask

   task automatic m_edge();
      bit found;
      m_err = 0;
      if (m_owner >= 0) begin
         m_held++;
         if (done) begin
            m_owner = -1; m_cool = 1;
         end else if (timeout_cfg != 0 && m_held == int'(timeout_cfg)) begin
            m_owner = -1; m_cool = 1; m_err = 1;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         found = 0;
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && eligible(c)) begin
               found = 1; m_owner = c; m_held = 0; m_id = c;
               m_ptr = (c + 1) % N;
               m_count = (m_count < (1 << CNTW) - 1) ? m_count + 1 : m_count;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("gnt_id", gnt_id, m_id);
      chk("busy", busy, (m_owner >= 0) ? 1 : 0);
      chk("err_to", err_to, m_err);
      chk("gnt_count", gnt_count, m_count);
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_grant(input string tag);
      for (int i = 0; i < 10 && gnt == '0; i++) step();
      chk(tag, busy, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] g [15];
      logic [N-1:0] tg [8];
      logic         te [8];
      int hi, nerr, ngr;
      bit saw1, saw3;
      logic [N-1:0] prev;

      rst_n = 1'b0; req = '0; cond = '0; mask = '0; timeout_cfg = '0; done = 1'b0;
      m_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Grant ch2, then reset asynchronously in the middle of BUSY
      cond = {4{8'h01}}; mask = 8'hFF; req = 4'b0100;
      wait_grant("ch2_busy");
      chk("ch2_gnt", gnt, 4'b0100);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", gnt, 0);
      chk("arst_id", gnt_id, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err_to, 0);
      chk("arst_cnt", gnt_count, 0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin with done one cycle after each grant
      req = 4'b1111;
      for (int s = 0; s < 15; s++) begin
         done = (gnt != '0);
         step();
         g[s] = gnt;
      end
      done = 1'b0;
      for (int s = 0; s < 15; s++) begin
         chk($sformatf("rr_step%0d", s), g[s], (s % 3 == 0) ? (32'd1 << ((s / 3) % 4)) : 32'd0);
      end
      chk("rr_count", gnt_count, 5);

      // Condition masking: ch1 condition is masked off
      do_reset();
      req = 4'b1010; cond = {8'h01, 8'h00, 8'h10, 8'h00}; mask = 8'h0F;
      saw1 = 0; saw3 = 0;
      for (int s = 0; s < 30; s++) begin
         done = (gnt != '0);
         step();
         if (gnt[1]) saw1 = 1;
         if (gnt[3]) saw3 = 1;
      end
      done = 1'b0;
      chk("mask_ch1_never", saw1, 0);
      chk("mask_ch3_seen", saw3, 1);

      // Timeout of 5 cycles, then pointer moves on
      do_reset();
      req = 4'b1111; cond = {4{8'h01}}; mask = 8'hFF; timeout_cfg = 6'd5;
      for (int s = 0; s < 8; s++) begin
         step();
         tg[s] = gnt; te[s] = err_to;
      end
      for (int s = 0; s < 8; s++) begin
         chk($sformatf("to_gnt%0d", s), tg[s], (s < 5) ? 32'h1 : (s == 7) ? 32'h2 : 32'h0);
         chk($sformatf("to_err%0d", s), te[s], (s == 5) ? 1 : 0);
      end

      // done on the 5th BUSY edge with timeout 5: no error
      repeat (4) step();
      chk("dn5_hold", gnt, 4'b0010);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("dn5_gnt", gnt, 0);
      chk("dn5_err", err_to, 0);

      // Timeout disabled, done withheld for 100 cycles
      timeout_cfg = '0;
      wait_grant("nto_busy");
      chk("nto_ch2", gnt, 4'b0100);
      hi = 1; nerr = 0;
      repeat (99) begin
         step();
         if (gnt != '0) hi++;
         if (err_to) nerr++;
      end
      done = 1'b1;
      step();
      done = 1'b0;
      chk("nto_hi", hi, 100);
      chk("nto_err", nerr, 0);
      chk("nto_rel", gnt, 0);

      // Dropping the request does not revoke the grant
      wait_grant("drop_busy");
      chk("drop_ch3", gnt, 4'b1000);
      req = '0; cond = '0;
      repeat (3) begin
         step();
         chk("drop_hold", gnt, 4'b1000);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      chk("drop_rel", gnt, 0);

      // Grant count saturation
      do_reset();
      req = 4'b1111; cond = {4{8'h01}}; mask = 8'hFF;
      ngr = 0; prev = '0;
      for (int s = 0; s < 60; s++) begin
         done = (gnt != '0);
         step();
         if (gnt != '0 && prev == '0) ngr++;
         prev = gnt;
      end
      done = 1'b0;
      chk("sat_grants", ngr, 20);
      chk("sat_count", gnt_count, 15);

      // Randomised traffic against the model
      do_reset();
      for (int s = 0; s < 1500; s++) begin
         req  = N'($urandom);
         cond = $urandom;
         mask = ($urandom_range(0, 7) == 0) ? '0 : CW'($urandom);
         done = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) timeout_cfg = TW'($urandom_range(0, 7));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
